// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU op sequencer.
//   - ALU select codes driven on the sel output
//   - ALUOp class codes from the main decoder
//   - R-type Func codes
//   - FSM state enum of the sequencer
package alu_ctrl_pkg;

    // ALU select codes
    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_MUL = 4'b0011;
    localparam logic [3:0] SEL_DIV = 4'b0100;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_NOP = 4'b1000;
    localparam logic [3:0] SEL_ILL = 4'b1111;

    // ALUOp classes
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    // R-type function codes
    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_SLT = 6'b101010;
    localparam logic [5:0] FUNC_NOP = 6'b000000;
    localparam logic [5:0] FUNC_MUL = 6'b000010;
    localparam logic [5:0] FUNC_DIV = 6'b011010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiply / divide, one bit per cycle over WIDTH cycles.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load operands and begin (ignored while busy)
//   mode         0 = multiply (shift-add), 1 = divide (restoring)
//   a, b         operands (a = multiplicand / dividend, b = multiplier / divisor)
//   busy         iteration in progress
//   done         final iteration happens this cycle; lo/hi carry the final value
//   lo, hi       low product / quotient and high product / remainder
// lo/hi show the result of the step being taken while busy, so the consumer can
// capture the final value on the same edge that retires the last step. Once
// idle they show the registered result, which stays put until the next start.
module iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] count;
    logic             mode_q;
    logic [WIDTH-1:0] acc_hi;   // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier shifting into product / dividend shifting into quotient
    logic [WIDTH-1:0] operand;  // multiplicand / divisor
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        step_hi   = acc_hi;
        step_lo   = acc_lo;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
        if (mode_q) begin
            // Borrow out of the top bit means the divisor did not fit: restore.
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    assign busy = (count != '0);
    assign done = (count == CNT_W'(1));
    assign lo   = busy ? step_lo : acc_lo;
    assign hi   = busy ? step_hi : acc_hi;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            mode_q  <= 1'b0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            operand <= '0;
        end else if (start && !busy) begin
            count   <= CNT_W'(WIDTH);
            mode_q  <= mode;
            acc_hi  <= '0;
            acc_lo  <= mode ? a : b;
            operand <= mode ? b : a;
        end else if (busy) begin
            count   <= count - CNT_W'(1);
            acc_hi  <= step_hi;
            acc_lo  <= step_lo;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU control decode plus execution with valid/ready handshakes on both sides.
// Single-cycle ops complete on the accept edge; MUL and DIV run on iter_muldiv.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operation handshake from decode
//   ALUOp, Func           op class and R-type function field
//   A, B                  operands
//   out_valid / out_ready result handshake towards EX/MEM
//   sel                   select code of the completed op
//   result, result_hi     primary result and high product / remainder
//   zero                  result == 0
//   illegal               unknown ALUOp/Func combination
//   div_by_zero           DIV with B == 0
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ALUOP_W = 3,
    parameter int FUNC_W  = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [FUNC_W-1:0]  Func,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         sel,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic               zero,
    output logic               illegal,
    output logic               div_by_zero
);

    state_t           state, state_nxt;
    logic [3:0]       dec_sel;
    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_dbz;
    logic             is_mul, is_div, accept, slot_free, md_start;
    logic             md_busy, md_done, md_is_div;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic             wr, wr_from_md;
    logic [3:0]       wr_sel;
    logic [WIDTH-1:0] wr_res, wr_hi;

    // Decode
    always_comb begin
        dec_sel = SEL_ILL;
        if (ALUOp == ALUOP_W'(ALUOP_ADD))      dec_sel = SEL_ADD;
        else if (ALUOp == ALUOP_W'(ALUOP_SUB)) dec_sel = SEL_SUB;
        else if (ALUOp == ALUOP_W'(ALUOP_AND)) dec_sel = SEL_AND;
        else if (ALUOp == ALUOP_W'(ALUOP_OR))  dec_sel = SEL_OR;
        else if (ALUOp == ALUOP_W'(ALUOP_SLT)) dec_sel = SEL_SLT;
        else if (ALUOp == ALUOP_W'(ALUOP_RTYPE)) begin
            case (Func)
                FUNC_W'(FUNC_ADD): dec_sel = SEL_ADD;
                FUNC_W'(FUNC_SUB): dec_sel = SEL_SUB;
                FUNC_W'(FUNC_AND): dec_sel = SEL_AND;
                FUNC_W'(FUNC_OR):  dec_sel = SEL_OR;
                FUNC_W'(FUNC_SLT): dec_sel = SEL_SLT;
                FUNC_W'(FUNC_NOP): dec_sel = SEL_NOP;
                FUNC_W'(FUNC_MUL): dec_sel = SEL_MUL;
                FUNC_W'(FUNC_DIV): dec_sel = SEL_DIV;
                default:           dec_sel = SEL_ILL;
            endcase
        end
    end

    // Single-cycle datapath. The DIV arm is only ever written out when B == 0;
    // a real divide goes to the iterative unit.
    always_comb begin
        sc_res = '0;
        sc_hi  = '0;
        sc_dbz = 1'b0;
        case (dec_sel)
            SEL_AND: sc_res = A & B;
            SEL_OR:  sc_res = A | B;
            SEL_ADD: sc_res = A + B;
            SEL_SUB: sc_res = A - B;
            SEL_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            SEL_DIV: begin
                sc_res = '1;
                sc_hi  = A;
                sc_dbz = 1'b1;
            end
            default: ;
        endcase
    end

    assign is_mul    = (dec_sel == SEL_MUL);
    assign is_div    = (dec_sel == SEL_DIV);
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = rst_n && (state == ST_IDLE) && !md_busy && slot_free;
    assign accept    = in_valid && in_ready;
    assign md_start  = accept && (is_mul || (is_div && (B != '0)));

    iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .mode  (is_div),
        .a     (A),
        .b     (B),
        .busy  (md_busy),
        .done  (md_done),
        .lo    (md_lo),
        .hi    (md_hi)
    );

    // FSM next state and output-register write enable
    always_comb begin
        state_nxt  = state;
        wr         = 1'b0;
        wr_from_md = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (md_start) state_nxt = is_mul ? ST_MUL : ST_DIV;
                    else          wr = 1'b1;
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_done) begin
                    if (slot_free) begin
                        wr         = 1'b1;
                        wr_from_md = 1'b1;
                        state_nxt  = ST_IDLE;
                    end else begin
                        state_nxt  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (slot_free) begin
                    wr         = 1'b1;
                    wr_from_md = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign wr_sel = wr_from_md ? (md_is_div ? SEL_DIV : SEL_MUL) : dec_sel;
    assign wr_res = wr_from_md ? md_lo : sc_res;
    assign wr_hi  = wr_from_md ? md_hi : sc_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            md_is_div <= 1'b0;
        end else begin
            state <= state_nxt;
            if (md_start) md_is_div <= is_div;
        end
    end

    // Output register: holds while stalled, drops valid and flags on handshake
    // unless a new result lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            sel         <= '0;
            result      <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            illegal     <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (wr) begin
            out_valid   <= 1'b1;
            sel         <= wr_sel;
            result      <= wr_res;
            result_hi   <= wr_hi;
            zero        <= (wr_res == '0);
            illegal     <= !wr_from_md && (dec_sel == SEL_ILL);
            div_by_zero <= !wr_from_md && sc_dbz;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
            illegal     <= 1'b0;
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer at WIDTH=8: directed cases followed
// by random ops with random back-pressure, scored against an arithmetic model.
module tb_alu_op_sequencer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       ALUOp = '0;
    logic [5:0]       Func = '0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [3:0]       sel;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             illegal;
    logic             div_by_zero;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(WIDTH), .ALUOP_W(3), .FUNC_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ALUOp       (ALUOp),
        .Func        (Func),
        .A           (A),
        .B           (B),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sel         (sel),
        .result      (result),
        .result_hi   (result_hi),
        .zero        (zero),
        .illegal     (illegal),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [3:0] sel;
        logic [7:0] res;
        logic [7:0] hi;
        logic       zero;
        logic       ill;
        logic       dbz;
        int         first_seen;  // negedges after the accept edge until out_valid is first seen
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   rdy_random = 1'b0;
    logic [5:0] legal_fn [8] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd2, 6'd26};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    // Reference model: straight from the op table, using integer arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [5:0] fn,
                                   input logic [7:0] a, input logic [7:0] b);
        exp_t  e;
        string kind;
        int    ua, ub, sa, sb, p;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        case (op)
            3'd0: kind = "add";
            3'd1: kind = "sub";
            3'd3: kind = "and";
            3'd4: kind = "or";
            3'd5: kind = "slt";
            3'd2: begin
                case (fn)
                    6'd32:   kind = "add";
                    6'd34:   kind = "sub";
                    6'd36:   kind = "and";
                    6'd37:   kind = "or";
                    6'd42:   kind = "slt";
                    6'd0:    kind = "nop";
                    6'd2:    kind = "mul";
                    6'd26:   kind = "div";
                    default: kind = "ill";
                endcase
            end
            default: kind = "ill";
        endcase
        e.sel = 4'hF; e.res = '0; e.hi = '0; e.ill = 1'b0; e.dbz = 1'b0; e.first_seen = 1;
        case (kind)
            "add": begin e.sel = 4'b0010; e.res = 8'((ua + ub) % 256); end
            "sub": begin e.sel = 4'b0110; e.res = 8'((ua - ub + 256) % 256); end
            "and": begin e.sel = 4'b0000; e.res = a & b; end
            "or":  begin e.sel = 4'b0001; e.res = a | b; end
            "slt": begin e.sel = 4'b0111; e.res = (sa < sb) ? 8'd1 : 8'd0; end
            "nop": begin e.sel = 4'b1000; end
            "mul": begin
                p = ua * ub;
                e.sel = 4'b0011; e.res = 8'(p % 256); e.hi = 8'(p / 256);
                e.first_seen = WIDTH + 1;
            end
            "div": begin
                e.sel = 4'b0100;
                if (ub == 0) begin
                    e.res = 8'hFF; e.hi = a; e.dbz = 1'b1;
                end else begin
                    e.res = 8'(ua / ub); e.hi = 8'(ua % ub);
                    e.first_seen = WIDTH + 1;
                end
            end
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 8'd0);
        return e;
    endfunction

    // Scoreboard: every result handshake is compared with the oldest accepted op.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {sel, result, result_hi, zero, illegal, div_by_zero},
                          {e.sel, e.res, e.hi, e.zero, e.ill, e.dbz});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_random) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    // Present an op and hold it until accepted; returns at accept edge + 1.
    task automatic send(input logic [2:0] op, input logic [5:0] fn, input logic [7:0] a,
                        input logic [7:0] b, output bit ok, output int waits);
        ALUOp = op; Func = fn; A = a; B = b; in_valid = 1'b1;
        ok = 1'b0; waits = 0;
        while (!ok && waits < 100) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                exp_q.push_back(model(op, fn, a, b));
            end
            @(posedge clk);
            #1;
            waits++;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    // Directed op with latency and busy-window checks (out_ready held high).
    task automatic dir(input string name, input logic [2:0] op, input logic [5:0] fn,
                       input logic [7:0] a, input logic [7:0] b);
        bit   ok;
        int   waits;
        int   seen = 0;
        int   lows = 0;
        exp_t e;
        e = model(op, fn, a, b);
        send(op, fn, a, b, ok, waits);
        if (ok) begin
            do begin
                @(negedge clk);
                seen++;
                if (!in_ready) lows++;
            end while (!out_valid && seen < 50);
            check({name, "_latency"}, seen, e.first_seen);
            if (e.first_seen > 1) check({name, "_in_ready_low"}, lows, WIDTH);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit         ok;
        int         waits;
        int         seen;
        logic [2:0] op;
        logic [5:0] fn;
        logic [7:0] ra, rb;
        logic [22:0] snap;

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {sel, result, result_hi, zero, illegal, div_by_zero}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        @(posedge clk); #1;

        dir("add",       3'b010, 6'b100000, 8'hF0, 8'h20);
        dir("slt_neg",   3'b010, 6'b101010, 8'hFF, 8'h01);
        dir("slt_swap",  3'b010, 6'b101010, 8'h01, 8'hFF);
        dir("mul",       3'b010, 6'b000010, 8'd200, 8'd3);
        dir("div",       3'b010, 6'b011010, 8'd100, 8'd7);
        dir("div0",      3'b010, 6'b011010, 8'd5, 8'd0);
        dir("ill_func",  3'b010, 6'b111111, 8'h12, 8'h34);
        dir("ill_op",    3'b111, 6'b100000, 8'h01, 8'h02);
        dir("sub_wrap",  3'b001, 6'b000000, 8'd3, 8'd5);
        dir("nop",       3'b010, 6'b000000, 8'h55, 8'hAA);
        dir("mul_max",   3'b010, 6'b000010, 8'hFF, 8'hFF);
        dir("div_small", 3'b010, 6'b011010, 8'd3, 8'd200);

        // Back-pressure: result must hold and block input until drained.
        out_ready = 1'b0;
        send(3'b010, 6'b100000, 8'h11, 8'h22, ok, waits);
        @(negedge clk);
        check("bp_out_valid", out_valid, 1);
        snap = {sel, result, result_hi, zero, illegal, div_by_zero};
        repeat (3) begin
            @(negedge clk);
            check("bp_hold", {sel, result, result_hi, zero, illegal, div_by_zero}, snap);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'b011, 6'b000000, 8'hCC, 8'h0F, ok, waits);
        check("bp_same_edge_accept", waits, 1);
        @(negedge clk);
        check("bp_next_result", out_valid, 1);
        @(posedge clk); #1;

        // Reset in the middle of a multiply: nothing may come out.
        send(3'b010, 6'b000010, 8'd77, 8'd91, ok, waits);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        seen = 0;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("post_rst_no_result", seen, 0);
        @(posedge clk); #1;

        // Random ops with random back-pressure.
        rdy_random = 1'b1;
        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom_range(0, 7));
            fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 7)];
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            send(op, fn, ra, rb, ok, waits);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        rdy_random = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        while (exp_q.size() != 0 && seen < 100) begin
            @(posedge clk); #1;
            seen++;
        end
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
